// File: rtl/load_store_unit.sv
// Data-memory initiator for RV32I loads and stores: one request at a time,
// sub-word stores via read-modify-write, a one-cycle response pulse per request.
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memWrite,
  output logic        mem_memRead,
  input  logic [31:0] mem_readData,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_RMW_READ = 3'd2,
    S_WRITE    = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;
  logic        error_q, error_d;

  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] st_merge;
  logic [31:0] word_index;
  logic        wr_cycle;

  assign dbg_state  = state_q;
  assign word_index = {2'b00, addr_q[31:2]};

  // Request checks are made on the live request so an error goes straight to RESP.
  always_comb begin
    req_err = 1'b0;
    if (req_write && (req_funct3 > 3'd2))
      req_err = 1'b1;
    if (!req_write && ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11)))
      req_err = 1'b1;
    if ((req_funct3[1:0] == 2'd1) && req_addr[0])
      req_err = 1'b1;
    if ((req_funct3 == 3'd2) && (req_addr[1:0] != 2'd0))
      req_err = 1'b1;
    if (req_addr[31:2] >= WORD_LIMIT)
      req_err = 1'b1;
  end

  // Load extension and store merge both act on the word arriving from memory.
  always_comb begin
    ld_byte  = mem_readData[{addr_q[1:0], 3'b000} +: 8];
    ld_half  = mem_readData[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_ext = {24'h0, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_readData;
    endcase
    st_merge = mem_readData;
    if (funct3_q == 3'd0)
      st_merge[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    else
      st_merge[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
  end

  // Handshake: a request transfers on the rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and req_valid may be held across busy cycles.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    funct3_d      = funct3_q;
    write_d       = write_q;
    error_d       = error_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = 32'h0;
    resp_error    = 1'b0;
    mem_address   = 32'h0;
    mem_writeData = 32'h0;
    mem_memRead   = 1'b0;
    wr_cycle      = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          write_d  = req_write;
          error_d  = req_err;
          data_d   = req_err ? 32'h0 : req_wdata;
          if (req_err)                  state_d = S_RESP;
          else if (!req_write)          state_d = S_READ;
          else if (req_funct3 == 3'd2)  state_d = S_WRITE;
          else                          state_d = S_RMW_READ;
        end
      end
      S_READ: begin
        mem_memRead = 1'b1;
        mem_address = word_index;
        data_d      = ld_ext;
        state_d     = S_RESP;
      end
      S_RMW_READ: begin
        mem_memRead = 1'b1;
        mem_address = word_index;
        data_d      = st_merge;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        wr_cycle      = 1'b1;
        mem_address   = word_index;
        mem_writeData = data_q;
        state_d       = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = write_q ? 32'h0 : data_q;
        resp_error = error_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Gated combinationally so a write coinciding with reset never commits.
    mem_memWrite = wr_cycle && !reset;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
      funct3_q <= 3'd0;
      write_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      funct3_q <= funct3_d;
      write_q  <= write_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a word memory, a request-level model of
// expected responses and memory writes, and one per-cycle compare process.
module tb_load_store_unit;

  localparam int MEM_WORDS = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memWrite;
  logic        mem_memRead;
  logic [31:0] mem_readData;
  logic [2:0]  dbg_state;

  always #5 clock = ~clock;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_readData(mem_readData), .dbg_state(dbg_state)
  );

  // Environment memory and model memory (model is updated at acceptance)
  logic [31:0] ram [0:MEM_WORDS-1];
  logic [31:0] mdl [0:MEM_WORDS-1];
  logic        ram_load = 1'b0;

  assign mem_readData = (mem_address < 32'(MEM_WORDS)) ? ram[mem_address[4:0]] : 32'h0;

  always @(posedge clock) begin
    if (ram_load) begin
      for (int i = 0; i < MEM_WORDS; i++) ram[i] <= mdl[i];
    end else if (mem_memWrite && (mem_address < 32'(MEM_WORDS))) begin
      ram[mem_address[4:0]] <= mem_writeData;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp_v);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event occurred at cycle %0d, required none", nm, cyc);
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    logic [31:0] idx;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] wr_q[$];
  exp_t        cur_e;
  int          cur_rd = 0;
  int          cur_wr = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;
  int          last_lat = 0;
  int          last_acc = 0;
  int          prev_acc = 0;

  // Request-level model: decides error, latency, strobes, load result, store effect.
  task automatic model_accept(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int acc);
    exp_t        e;
    logic [31:0] idx, word, nw, b, h;
    int          bs, hs;
    logic        err;
    idx = {2'b00, a[31:2]};
    err = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) err = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'd0) err = 1'b1;
    if (idx >= 32'(MEM_WORDS)) err = 1'b1;
    e.idx = idx; e.acc = acc; e.err = err; e.rdata = 32'h0;
    bs = 8 * int'(a[1:0]);
    hs = 16 * int'(a[1]);
    if (err) begin
      e.lat = 1; e.nrd = 0; e.nwr = 0;
    end else begin
      word = mdl[idx[4:0]];
      b = (word >> bs) & 32'hFF;
      h = (word >> hs) & 32'hFFFF;
      if (!w) begin
        e.lat = 2; e.nrd = 1; e.nwr = 0;
        case (f3)
          3'd0: e.rdata = b[7] ? (b | 32'hFFFFFF00) : b;
          3'd4: e.rdata = b;
          3'd1: e.rdata = h[15] ? (h | 32'hFFFF0000) : h;
          3'd5: e.rdata = h;
          default: e.rdata = word;
        endcase
      end else begin
        e.nwr = 1;
        if (f3 == 3'd2) begin
          e.lat = 2; e.nrd = 0; nw = wd;
        end else if (f3 == 3'd0) begin
          e.lat = 3; e.nrd = 1;
          nw = (word & ~(32'hFF << bs)) | ((wd & 32'hFF) << bs);
        end else begin
          e.lat = 3; e.nrd = 1;
          nw = (word & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
        end
        mdl[idx[4:0]] = nw;
        wr_q.push_back({idx, nw});
      end
    end
    exp_q.push_back(e);
  endtask

  // Per-cycle compare against the model queues
  always @(negedge clock) begin
    if (reset) begin
      chk1("memwrite_during_reset", mem_memWrite, 1'b0);
      cur_rd = 0;
      cur_wr = 0;
    end else begin
      chk1("rd_wr_exclusive", mem_memRead && mem_memWrite, 1'b0);
      chk1("req_ready", req_ready, exp_q.size() == 0);
      if (mem_memRead) begin
        cur_rd++;
        if (exp_q.size() == 0) fail_now("unexpected_read");
        else chk("read_addr", mem_address, exp_q[0].idx);
      end
      if (mem_memWrite) begin
        cur_wr++;
        if (wr_q.size() == 0) fail_now("unexpected_write");
        else begin
          chk("write_addr", mem_address, wr_q[0][63:32]);
          chk("write_data", mem_writeData, wr_q[0][31:0]);
          void'(wr_q.pop_front());
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_resp");
        else begin
          cur_e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, cur_e.rdata);
          chk1("resp_error", resp_error, cur_e.err);
          chk("resp_latency", 32'(cyc - cur_e.acc + 1), 32'(cur_e.lat));
          chk("read_strobes", 32'(cur_rd), 32'(cur_e.nrd));
          chk("write_strobes", 32'(cur_wr), 32'(cur_e.nwr));
          last_rdata = resp_rdata;
          last_err   = resp_error;
          last_lat   = cyc - cur_e.acc + 1;
        end
        cur_rd = 0;
        cur_wr = 0;
      end else begin
        chk("idle_rdata", resp_rdata, 32'h0);
        chk1("idle_error", resp_error, 1'b0);
      end
    end
  end

  // Drivers: all run at posedge+#1
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
    int n;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (!req_ready) begin
      fail_now("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    prev_acc = last_acc;
    last_acc = cyc;
    model_accept(w, f3, a, wd, cyc);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now("resp_timeout");
      exp_q.delete();
      wr_q.delete();
    end
  endtask

  task automatic do_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    issue(w, f3, a, wd, 1'b0);
    wait_done();
  endtask

  task automatic ld_lit(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] exp_v);
    do_op(1'b0, f3, a, 32'h0);
    chk(nm, last_rdata, exp_v);
  endtask

  task automatic err_lit(input string nm, input logic w, input logic [2:0] f3,
                         input logic [31:0] a);
    do_op(w, f3, a, 32'hFFFF_FFFF);
    chk1({nm, "_err"}, last_err, 1'b1);
    chk({nm, "_rdata"}, last_rdata, 32'h0);
    chk({nm, "_lat"}, 32'(last_lat), 32'd1);
  endtask

  logic [31:0] saved;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mdl[i] = $urandom;
    ram_load = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    ram_load = 1'b0;
    reset = 1'b0;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk1("rst_resp_error", resp_error, 1'b0);
    chk1("rst_memwrite", mem_memWrite, 1'b0);
    chk1("rst_memread", mem_memRead, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_writedata", mem_writeData, 32'h0);

    // Word store and load
    do_op(1'b1, 3'd2, 32'h8, 32'hDEADBEEF);
    chk("sw_lat", 32'(last_lat), 32'd2);
    chk1("sw_err", last_err, 1'b0);
    chk("sw_ram", ram[2], 32'hDEADBEEF);
    ld_lit("lw_8", 3'd2, 32'h8, 32'hDEADBEEF);
    chk("lw_lat", 32'(last_lat), 32'd2);

    // Sub-word stores
    do_op(1'b1, 3'd0, 32'h9, 32'h00000055);
    chk("sb_ram", ram[2], 32'hDEAD55EF);
    chk("sb_lat", 32'(last_lat), 32'd3);
    do_op(1'b1, 3'd1, 32'hA, 32'h00001234);
    chk("sh_ram", ram[2], 32'h123455EF);
    chk("sh_model", mdl[2], 32'h123455EF);

    // Extending loads
    ld_lit("lb_8", 3'd0, 32'h8, 32'hFFFFFFEF);
    ld_lit("lbu_8", 3'd4, 32'h8, 32'h000000EF);
    ld_lit("lh_A", 3'd1, 32'hA, 32'h00001234);
    ld_lit("lhu_8", 3'd5, 32'h8, 32'h000055EF);
    ld_lit("lb_B", 3'd0, 32'hB, 32'h00000012);
    for (int a = 0; a < 4; a++) begin
      do_op(1'b0, 3'd0, 32'h14 + 32'(a), 32'h0);
      do_op(1'b0, 3'd4, 32'h14 + 32'(a), 32'h0);
    end
    do_op(1'b0, 3'd1, 32'h16, 32'h0);
    do_op(1'b0, 3'd5, 32'h16, 32'h0);
    do_op(1'b1, 3'd0, 32'h7F, 32'h0000_00A7);
    do_op(1'b0, 3'd2, 32'h7C, 32'h0);

    // Error cases
    err_lit("lw_misaligned", 1'b0, 3'd2, 32'h6);
    err_lit("sh_misaligned", 1'b1, 3'd1, 32'h3);
    err_lit("lw_out_of_range", 1'b0, 3'd2, 32'h80);
    err_lit("load_funct3_3", 1'b0, 3'd3, 32'h0);
    err_lit("store_funct3_4", 1'b1, 3'd4, 32'h0);
    chk("after_errors_ram2", ram[2], 32'h123455EF);

    // Reset during the WRITE cycle of a word store
    saved = ram[1];
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h4; req_wdata = 32'hFFFFFFFF;
    chk1("abort_ready", req_ready, 1'b1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("abort_write_addr", mem_address, 32'h1);
    reset = 1'b1;
    #1;
    chk1("abort_memwrite", mem_memWrite, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk1("ready_after_reset", req_ready, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    chk("abort_ram_unchanged", ram[1], saved);
    ld_lit("abort_readback", 3'd2, 32'h4, saved);

    // Back-to-back with req_valid held
    issue(1'b1, 3'd2, 32'h10, 32'hA5A55A5A, 1'b1);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    wait_done();
    chk("b2b_accept_gap", 32'(last_acc - prev_acc), 32'd3);
    chk("b2b_lw", last_rdata, 32'hA5A55A5A);

    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
